// File: rtl/ifft_4pt_seq.sv
// ifft_4pt_seq: sequential 4-point radix-2 DIT inverse FFT with 1/N scaling.
// One add/subtract butterfly is shared across 2 stages x 2 butterflies.
// The twiddles are only 1 and +j, so the +j rotation is a swap plus a negate.
// Optional macro IFFT_ROUND_EN: each halving rounds half-up and saturates.
// When the macro is undefined, each halving is a plain floor shift.
module ifft_4pt_seq #(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0][DATA_W-1:0] x_r,
  input  logic [3:0][DATA_W-1:0] x_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0][DATA_W-1:0] Xout_r,
  output logic [3:0][DATA_W-1:0] Xout_i
);

  // One guard bit: a +/- b for DATA_W operands (b possibly negated) always fits.
  localparam int EW = DATA_W + 1;
  typedef logic signed [EW-1:0] ext_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1A  = 3'd1,
    S1B  = 3'd2,
    S2A  = 3'd3,
    S2B  = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic ext_t sext(input logic [DATA_W-1:0] v);
    return ext_t'($signed(v));
  endfunction

`ifdef IFFT_ROUND_EN
  typedef logic signed [EW:0] wide_t;
  localparam wide_t SAT_MAX = wide_t'({{3{1'b0}}, {(DATA_W-1){1'b1}}});
  localparam wide_t SAT_MIN = wide_t'({{3{1'b1}}, {(DATA_W-1){1'b0}}});

  // Round half-up. The +1 can push 2^DATA_W-1 up to 2^DATA_W, so the sum uses one more bit.
  function automatic logic [DATA_W-1:0] halve(input ext_t s);
    wide_t t;
    t = (wide_t'(s) + wide_t'(1'b1)) >>> 1;
    if (t > SAT_MAX) begin
      return DATA_W'(SAT_MAX);
    end else if (t < SAT_MIN) begin
      return DATA_W'(SAT_MIN);
    end else begin
      return DATA_W'(t);
    end
  endfunction
`else
  // Floor halving: the arithmetic shift brings the value back to DATA_W without overflow.
  function automatic logic [DATA_W-1:0] halve(input ext_t s);
    return DATA_W'(s >>> 1);
  endfunction
`endif

  state_t                  state_q, state_d;
  logic [3:0][DATA_W-1:0]  wr_q, wr_d, wi_q, wi_d;
  logic [3:0][DATA_W-1:0]  yr_q, yr_d, yi_q, yi_d;
  logic                    out_valid_q, out_valid_d;

  logic [DATA_W-1:0]       op_a_r_s, op_a_i_s, op_b_r_s, op_b_i_s;
  logic                    rot_s;
  ext_t                    b_r_e_s, b_i_e_s;
  ext_t                    sum_r_s, sum_i_s, dif_r_s, dif_i_s;
  logic [DATA_W-1:0]       hs_r_s, hs_i_s, hd_r_s, hd_i_s;

  // Route the operand pair for the current butterfly step into the shared adder.
  always_comb begin
    op_a_r_s = '0;
    op_a_i_s = '0;
    op_b_r_s = '0;
    op_b_i_s = '0;
    rot_s    = 1'b0;
    case (state_q)
      S1A: begin
        op_a_r_s = wr_q[0]; op_a_i_s = wi_q[0];
        op_b_r_s = wr_q[2]; op_b_i_s = wi_q[2];
      end
      S1B: begin
        op_a_r_s = wr_q[1]; op_a_i_s = wi_q[1];
        op_b_r_s = wr_q[3]; op_b_i_s = wi_q[3];
      end
      S2A: begin
        op_a_r_s = wr_q[0]; op_a_i_s = wi_q[0];
        op_b_r_s = wr_q[1]; op_b_i_s = wi_q[1];
      end
      S2B: begin
        op_a_r_s = wr_q[2]; op_a_i_s = wi_q[2];
        op_b_r_s = wr_q[3]; op_b_i_s = wi_q[3];
        rot_s    = 1'b1;
      end
      default: begin
        rot_s = 1'b0;
      end
    endcase
  end

  // Apply the +j twiddle as swap/negate. The negate is done in the wide type so -(-2^(W-1)) fits.
  always_comb begin
    if (rot_s) begin
      b_r_e_s = -sext(op_b_i_s);
      b_i_e_s = sext(op_b_r_s);
    end else begin
      b_r_e_s = sext(op_b_r_s);
      b_i_e_s = sext(op_b_i_s);
    end
  end

  assign sum_r_s = sext(op_a_r_s) + b_r_e_s;
  assign sum_i_s = sext(op_a_i_s) + b_i_e_s;
  assign dif_r_s = sext(op_a_r_s) - b_r_e_s;
  assign dif_i_s = sext(op_a_i_s) - b_i_e_s;

  assign hs_r_s = halve(sum_r_s);
  assign hs_i_s = halve(sum_i_s);
  assign hd_r_s = halve(dif_r_s);
  assign hd_i_s = halve(dif_i_s);

  // Sequencing and next-state values. Stage-1 results overwrite the input slots in place.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wi_d        = wi_q;
    yr_d        = yr_q;
    yi_d        = yi_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_d    = x_r;
          wi_d    = x_i;
          state_d = S1A;
        end else begin
          state_d = IDLE;
        end
      end
      S1A: begin
        wr_d[0] = hs_r_s; wi_d[0] = hs_i_s;
        wr_d[2] = hd_r_s; wi_d[2] = hd_i_s;
        state_d = S1B;
      end
      S1B: begin
        wr_d[1] = hs_r_s; wi_d[1] = hs_i_s;
        wr_d[3] = hd_r_s; wi_d[3] = hd_i_s;
        state_d = S2A;
      end
      S2A: begin
        yr_d[0] = hs_r_s; yi_d[0] = hs_i_s;
        yr_d[2] = hd_r_s; yi_d[2] = hd_i_s;
        state_d = S2B;
      end
      S2B: begin
        yr_d[1]     = hs_r_s; yi_d[1] = hs_i_s;
        yr_d[3]     = hd_r_s; yi_d[3] = hd_i_s;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            wr_d    = x_r;
            wi_d    = x_i;
            state_d = S1A;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, working and result registers. Reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      wi_q        <= '0;
      yr_q        <= '0;
      yi_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      wi_q        <= wi_d;
      yr_q        <= yr_d;
      yi_q        <= yi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign Xout_r    = yr_q;
  assign Xout_i    = yi_q;

endmodule

// File: tb/tb_ifft_4pt_seq.sv
// Testbench for ifft_4pt_seq.
// Expected results come from a twiddle-table model with per-stage halving.
// Directed frames are also checked against hand-computed literals.
module tb_ifft_4pt_seq;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][7:0] x_r, x_i;
  logic            out_valid;
  logic            out_ready;
  logic [3:0][7:0] Xout_r, Xout_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0][31:0] r;
    logic [3:0][31:0] i;
  } cfrm_t;

  cfrm_t exp_q[$];
  int    acc_q[$];
  cfrm_t cur;
  logic  have_cur = 1'b0;
  logic  prev_valid = 1'b0;
  int    cyc = 0;

  ifft_4pt_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_r(x_r), .x_i(x_i), .out_valid(out_valid), .out_ready(out_ready),
    .Xout_r(Xout_r), .Xout_i(Xout_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int half(input int s);
`ifdef IFFT_ROUND_EN
    int t;
    t = (s + 1) >>> 1;
    if (t > 127) return 127;
    else if (t < -128) return -128;
    else return t;
`else
    return s >>> 1;
`endif
  endfunction

  // X_k = sum over stages: pairs (n, n+2) first, then combine with twiddle j^k.
  function automatic cfrm_t model(input logic [3:0][7:0] fr, input logic [3:0][7:0] fi);
    int xr[4];
    int xi[4];
    int ar[2];
    int ai[2];
    int br[2];
    int bi[2];
    int tw_r[4];
    int tw_i[4];
    cfrm_t o;
    tw_r = '{1, 0, -1, 0};
    tw_i = '{0, 1, 0, -1};
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($signed(fr[n]));
      xi[n] = int'($signed(fi[n]));
    end
    for (int m = 0; m < 2; m++) begin
      int sg;
      sg = (m == 0) ? 1 : -1;
      ar[m] = half(xr[0] + sg * xr[2]);
      ai[m] = half(xi[0] + sg * xi[2]);
      br[m] = half(xr[1] + sg * xr[3]);
      bi[m] = half(xi[1] + sg * xi[3]);
    end
    for (int k = 0; k < 4; k++) begin
      int m, pr, pi;
      m  = k % 2;
      pr = tw_r[k] * br[m] - tw_i[k] * bi[m];
      pi = tw_r[k] * bi[m] + tw_i[k] * br[m];
      o.r[k] = half(ar[m] + pr);
      o.i[k] = half(ai[m] + pi);
    end
    return o;
  endfunction

  function automatic logic [3:0][7:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][7:0] f;
    f[0] = a[7:0];
    f[1] = b[7:0];
    f[2] = c[7:0];
    f[3] = d[7:0];
    return f;
  endfunction

  // Scoreboard: queue the model result on each handshake and check latency on each out_valid rise.
  // While out_valid is high, compare every output sample against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      have_cur   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      cyc++;
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
          have_cur = 1'b0;
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          chk("latency", cyc - acc_q.pop_front(), 5);
        end
      end
      if (out_valid && have_cur) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("model_r%0d", k), int'($signed(Xout_r[k])), int'($signed(cur.r[k])));
          chk($sformatf("model_i%0d", k), int'($signed(Xout_i[k])), int'($signed(cur.i[k])));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(x_r, x_i));
        acc_q.push_back(cyc);
      end
      prev_valid = out_valid;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0][7:0] fr, input logic [3:0][7:0] fi);
    int  n;
    logic acc;
    n   = 0;
    x_r = fr;
    x_i = fi;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end while (!acc && n < 50);
    chk("accept_timeout", int'(acc), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic expect_out(input string nm, input int r0, input int r1, input int r2,
                            input int r3, input int i0, input int i1, input int i2, input int i3);
    int er[4];
    int ei[4];
    er = '{r0, r1, r2, r3};
    ei = '{i0, i1, i2, i3};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_r%0d", nm, k), int'($signed(Xout_r[k])), er[k]);
      chk($sformatf("%s_i%0d", nm, k), int'($signed(Xout_i[k])), ei[k]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0] z;
    logic [3:0][7:0] held_r, held_i;
    cfrm_t m;
    z = mk(0, 0, 0, 0);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_r = z; x_i = z;

    // Pin the model itself with hand-computed values.
    m = model(mk(100, 0, 0, 0), z);
    chk("pin_imp_r3", int'($signed(m.r[3])), 25);
    m = model(mk(0, 64, 0, 0), z);
    chk("pin_shift_r2", int'($signed(m.r[2])), -16);
    chk("pin_shift_i3", int'($signed(m.i[3])), -16);
    m = model(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128));
    chk("pin_ext_r0", int'($signed(m.r[0])), -128);

    repeat (2) align();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_xout_r", int'(Xout_r), 0);
    chk("rst_xout_i", int'(Xout_i), 0);

    out_ready = 1'b1;
    align(); send(mk(100, 0, 0, 0), z); wait_valid();
    expect_out("impulse", 25, 25, 25, 25, 0, 0, 0, 0);

    align(); send(mk(0, 64, 0, 0), z); wait_valid();
    expect_out("shifted", 16, 0, -16, 0, 0, 16, 0, -16);

    align(); send(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128)); wait_valid();
    expect_out("extreme", -128, 0, 0, 0, -128, 0, 0, 0);

    align(); send(mk(-1, 0, 0, 0), z); wait_valid();
`ifdef IFFT_ROUND_EN
    expect_out("floor", 0, 0, 0, 0, 0, 0, 0, 0);
`else
    expect_out("floor", -1, -1, -1, -1, 0, 0, 0, 0);
`endif

    // Backpressure: hold the result in DONE, then accept a new frame on release.
    align(); out_ready = 1'b0;
    send(mk(10, -20, 30, -40), mk(5, 6, 7, 8)); wait_valid();
    held_r = Xout_r; held_i = Xout_i;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_hold_r", int'(Xout_r), int'(held_r));
      chk("bp_hold_i", int'(Xout_i), int'(held_i));
    end
    align(); out_ready = 1'b1;
    send(mk(64, 64, 64, 64), z); wait_valid();
    expect_out("dc", 64, 0, 0, 0, 0, 0, 0, 0);

    // Busy ignore: a different frame offered during S1B must not be taken.
    align(); send(mk(100, 0, 0, 0), z);
    align();
    x_r = mk(50, 50, 50, 50); x_i = mk(7, 7, 7, 7); in_valid = 1'b1;
    align();
    in_valid = 1'b0;
    wait_valid();
    expect_out("busy", 25, 25, 25, 25, 0, 0, 0, 0);

    // Mid-operation reset during S2A.
    align(); send(mk(80, 0, 0, 0), z);
    align(); align();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_xout_r", int'(Xout_r), 0);
    chk("midrst_xout_i", int'(Xout_i), 0);
    @(negedge clk);
    align(); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_no_valid", int'(out_valid), 0);
    align(); send(mk(80, 0, 0, 0), z); wait_valid();
    expect_out("post_rst", 20, 20, 20, 20, 0, 0, 0, 0);

    align(); align();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
